// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow between bits.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one operand bit pair consumed per edge, LSB first
// DONE  | one-cycle result strobe; a new start is accepted here too
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_b, accept, last;

  assign cell_d = a_sr[0] ^ b_sr[0] ^ brw;
  assign cell_b = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state != SHIFT) && start;

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        brw  <= bin;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sr <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr <= {1'b0, b_sr[WIDTH-1:1]};
        r_sr <= {cell_d, r_sr[WIDTH-1:1]};
        brw  <= cell_b;
        cnt  <= cnt + 1'b1;
        // the final bit goes straight to the outputs so no partial result is ever visible
        if (last) begin
          diff <= {cell_d, r_sr[WIDTH-1:1]};
          bout <= cell_b;
        end
      end
    end
  end

endmodule
